// File: rtl/act_pkg.sv
// Shared definitions for the activation scheduler: function-select codes.
package act_pkg;

  localparam int FUNC_W = 2;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_RELU     = 2'b00,
    FUNC_LEAKY    = 2'b01,
    FUNC_HARDTANH = 2'b10,
    FUNC_SIGMOID  = 2'b11
  } func_e;

endpackage

// File: rtl/act_func_unit.sv
// Purely combinational activation datapath: (data, func) -> result in signed
// fixed point with DECIMAL_POINT fractional bits.
module act_func_unit
  import act_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DECIMAL_POINT   = 6,
  parameter int NEG_SLOPE_SHIFT = 5
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic [FUNC_W-1:0] func_i,
  output logic [WIDTH-1:0]  result_o
);

  localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(1 << DECIMAL_POINT);
  localparam logic signed [WIDTH-1:0] NEG_ONE   = -ONE;
  localparam logic [WIDTH-1:0]        MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        HALF      = WIDTH'(1 << (DECIMAL_POINT-1));
  localparam logic [WIDTH-1:0]        FRAC_MASK = WIDTH'((1 << DECIMAL_POINT) - 1);
  localparam logic [WIDTH-1:0]        WIDTH_L   = WIDTH'(WIDTH);

  logic signed [WIDTH-1:0] x;
  logic [WIDTH-1:0]        mag;
  logic [WIDTH-1:0]        k;
  logic [WIDTH-1:0]        frac;
  logic [WIDTH-1:0]        sig_y;
  logic [WIDTH-1:0]        sig_out;

  always_comb begin
    x = signed'(data_i);
    // |x|, with the most-negative code clamped so it stays representable
    if (!x[WIDTH-1])            mag = data_i;
    else if (data_i == MOST_NEG) mag = MAX_POS;
    else                        mag = unsigned'(-x);
    k       = mag >> DECIMAL_POINT;
    frac    = mag & FRAC_MASK;
    sig_y   = (k >= WIDTH_L) ? '0 : ((HALF - (frac >> 2)) >> k);
    sig_out = x[WIDTH-1] ? sig_y : (unsigned'(ONE) - sig_y);

    case (func_i)
      FUNC_RELU:     result_o = x[WIDTH-1] ? '0 : data_i;
      FUNC_LEAKY:    result_o = x[WIDTH-1] ? unsigned'(x >>> NEG_SLOPE_SHIFT) : data_i;
      FUNC_HARDTANH: result_o = (x > ONE) ? unsigned'(ONE)
                              : (x < NEG_ONE) ? unsigned'(NEG_ONE) : data_i;
      default:       result_o = sig_out;
    endcase
  end

endmodule

// File: rtl/act_func_scheduler.sv
// Round-robin sharing of one activation unit among NUM_REQ requesters through
// a capture stage (A) and a compute/output stage (B), with full backpressure.
module act_func_scheduler
  import act_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DECIMAL_POINT   = 6,
  parameter int NEG_SLOPE_SHIFT = 5,
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*FUNC_W-1:0] req_func,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ID_W-1:0]           out_id,
  output logic [FUNC_W-1:0]         out_func,
  output logic                      busy
);

  logic [WIDTH-1:0]  a_data_q, a_data_d;
  logic [FUNC_W-1:0] a_func_q, a_func_d;
  logic [ID_W-1:0]   a_id_q, a_id_d;
  logic              a_valid_q, a_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [FUNC_W-1:0] out_func_q, out_func_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              adv_a, adv_b, found;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  fu_result;

  // Valid/ready contract on both sides: a transfer happens on a rising edge
  // where valid & ready are both high; a source holds its payload while
  // valid & !ready, and may drop valid before the transfer (it is re-arbitrated).
  assign adv_b = !out_valid_q || out_ready;
  assign adv_a = !a_valid_q || adv_b;

  // Priority starts just after the last granted requester and wraps.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(ptr_q))) begin
        found     = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i <= int'(ptr_q))) begin
        found     = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  assign req_ready = (found && adv_a && !iRst) ? (NUM_REQ'(1) << grant_idx) : '0;

  act_func_unit #(
    .WIDTH           (WIDTH),
    .DECIMAL_POINT   (DECIMAL_POINT),
    .NEG_SLOPE_SHIFT (NEG_SLOPE_SHIFT)
  ) u_func (
    .data_i   (a_data_q),
    .func_i   (a_func_q),
    .result_o (fu_result)
  );

  always_comb begin
    a_data_d    = a_data_q;
    a_func_d    = a_func_q;
    a_id_d      = a_id_q;
    a_valid_d   = a_valid_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_func_d  = out_func_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;

    if (adv_a) begin
      a_valid_d = found;
      if (found) begin
        a_data_d = req_data[int'(grant_idx)*WIDTH +: WIDTH];
        a_func_d = req_func[int'(grant_idx)*FUNC_W +: FUNC_W];
        a_id_d   = grant_idx;
        ptr_d    = grant_idx;
      end
    end

    if (adv_b) begin
      out_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_data_d = fu_result;
        out_func_d = a_func_q;
        out_id_d   = a_id_q;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_data_q    <= '0;
      a_func_q    <= '0;
      a_id_q      <= '0;
      a_valid_q   <= 1'b0;
      out_data_q  <= '0;
      out_func_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= ID_W'(NUM_REQ-1);
    end else begin
      a_data_q    <= a_data_d;
      a_func_q    <= a_func_d;
      a_id_q      <= a_id_d;
      a_valid_q   <= a_valid_d;
      out_data_q  <= out_data_d;
      out_func_q  <= out_func_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_func  = out_func_q;
  assign busy      = a_valid_q || out_valid_q;

endmodule

// File: tb/tb_act_func_scheduler.sv
// Bench for act_func_scheduler: queue-based reference model checked every
// cycle, plus directed vectors with literal expected results.
module tb_act_func_scheduler;

  localparam int NR = 4;

  logic          iClk;
  logic          iRst;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [31:0]   req_data  = '0;
  logic [7:0]    req_func  = '0;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_id;
  logic [1:0]    out_func;
  logic          busy;

  act_func_scheduler dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_func  (req_func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_func  (out_func),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_act(input logic [7:0] d, input logic [1:0] fn);
    int x, a, k, f, y, r;
    x = int'(signed'(d));
    case (fn)
      2'd0: r = (x < 0) ? 0 : x;
      2'd1: r = (x < 0) ? (x >>> 5) : x;
      2'd2: r = (x > 64) ? 64 : ((x < -64) ? -64 : x);
      default: begin
        a = (x == -128) ? 127 : ((x < 0) ? -x : x);
        k = a / 64;
        f = a % 64;
        y = (k >= 8) ? 0 : ((32 - f / 4) >> k);
        r = (x < 0) ? y : 64 - y;
      end
    endcase
    return 8'(r);
  endfunction

  logic [11:0] exp_q[$];       // {id, func, result} in issue order
  int          exp_edge_q[$];  // edge at which each item was accepted
  logic [11:0] obs_q[$];       // delivered results {id, func, data}
  int          obs_edge_q[$];  // edge at which each result was taken
  int          hs_edge_q[$];   // edge at which each request was accepted
  int          n_edge = 0;
  int          m_ptr  = NR - 1;

  always begin : compare
    int          gi;
    logic [NR-1:0] exp_rdy;
    logic        adv, exp_ov, in_hs, out_hs;
    logic [7:0]  in_d;
    logic [1:0]  in_f;
    @(negedge iClk);
    in_hs  = 1'b0;
    out_hs = 1'b0;
    gi     = -1;
    in_d   = '0;
    in_f   = '0;
    if (iRst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_out_func", out_func, 0);
      exp_q.delete();
      exp_edge_q.delete();
      m_ptr = NR - 1;
    end else begin
      adv = (exp_q.size() < 2) || out_ready;
      if (adv) begin
        for (int s = 1; s <= NR; s++) begin
          if (gi < 0 && req_valid[(m_ptr + s) % NR]) gi = (m_ptr + s) % NR;
        end
      end
      exp_rdy = (gi >= 0) ? NR'(1 << gi) : '0;
      check("req_ready", req_ready, exp_rdy);
      exp_ov = (exp_q.size() > 0) && (exp_edge_q[0] + 1 <= n_edge);
      check("out_valid", out_valid, exp_ov);
      check("busy", busy, exp_q.size() > 0);
      if (exp_ov) begin
        check("out_data", out_data, exp_q[0][7:0]);
        check("out_func", out_func, exp_q[0][9:8]);
        check("out_id", out_id, exp_q[0][11:10]);
      end
      if (gi >= 0) begin
        in_hs = 1'b1;
        in_d  = req_data[gi*8 +: 8];
        in_f  = req_func[gi*2 +: 2];
      end
      out_hs = exp_ov && out_ready;
      if (out_valid && out_ready) begin
        obs_q.push_back({out_id, out_func, out_data});
        obs_edge_q.push_back(n_edge + 1);
      end
      if ((req_valid & req_ready) != '0) hs_edge_q.push_back(n_edge + 1);
    end
    @(posedge iClk);
    n_edge++;
    if (out_hs) begin
      void'(exp_q.pop_front());
      void'(exp_edge_q.pop_front());
    end
    if (in_hs) begin
      exp_q.push_back({2'(gi), in_f, model_act(in_d, in_f)});
      exp_edge_q.push_back(n_edge);
      m_ptr = gi;
    end
  end

  // ---------------- driver ----------------
  logic [9:0] drv_q [NR][$];  // per requester {func, data}

  always begin : driver
    logic [NR-1:0] acc;
    @(negedge iClk);
    acc = req_valid & req_ready;
    @(posedge iClk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      if (drv_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = drv_q[i][0][7:0];
        req_func[i*2 +: 2] = drv_q[i][0][9:8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  function automatic int pending_items();
    int n = 0;
    for (int i = 0; i < NR; i++) n += drv_q[i].size();
    return n;
  endfunction

  task automatic drain(input int budget);
    int cyc = 0;
    while ((pending_items() > 0 || busy) && cyc < budget) begin
      @(posedge iClk);
      #2;
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending items, expected 0", pending_items());
    end
  endtask

  task automatic do_reset();
    @(posedge iClk);
    #2 iRst = 1'b1;
    @(negedge iClk);
    @(posedge iClk);
    #1 iRst = 1'b0;
    #1;
  endtask

  task automatic load_all(input int per_req);
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < per_req; k++)
        drv_q[r].push_back({2'((r + k) % 4), 8'(r * 53 + k * 29 + 7)});
  endtask

  task automatic check_rr_ids(input string name, input int n);
    check({name, "_count"}, obs_q.size(), n);
    for (int j = 0; j < n && j < obs_q.size(); j++)
      check({name, "_id"}, obs_q[j][11:10], j % NR);
  endtask

  // ---------------- directed vectors ----------------
  logic [7:0] vec_in  [10];
  logic [1:0] vec_fn  [10];
  logic [7:0] vec_out [10];

  initial begin
    vec_in  = '{8'hC0, 8'h20, 8'h80, 8'h50, 8'hA0, 8'h30, 8'h00, 8'h40, 8'hC0, 8'h80};
    vec_fn  = '{2'd0,  2'd0,  2'd1,  2'd2,  2'd2,  2'd2,  2'd3,  2'd3,  2'd3,  2'd3};
    vec_out = '{8'h00, 8'h20, 8'hFC, 8'h40, 8'hC0, 8'h30, 8'h20, 8'h30, 8'h10, 8'h08};
    iRst      = 1'b1;
    out_ready = 1'b1;

    // Reset state, with a request pending while reset is held.
    repeat (3) @(posedge iClk);
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    drv_q[1].push_back({2'd0, 8'h11});
    @(posedge iClk);
    #2;
    check("reset_blocks_ready", req_ready, 0);
    @(posedge iClk);
    #1 iRst = 1'b0;
    drain(50);
    check("first_item_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("first_item", obs_q[0], {2'd1, 2'd0, 8'h11});

    // Single requester 0 through every function.
    obs_q.delete();
    obs_edge_q.delete();
    hs_edge_q.delete();
    for (int j = 0; j < 10; j++) drv_q[0].push_back({vec_fn[j], vec_in[j]});
    drain(100);
    check("vec_count", obs_q.size(), 10);
    for (int j = 0; j < 10 && j < obs_q.size(); j++) begin
      check("vec_data", obs_q[j][7:0], vec_out[j]);
      check("vec_func", obs_q[j][9:8], vec_fn[j]);
      check("vec_id", obs_q[j][11:10], 0);
    end
    if (obs_edge_q.size() > 1 && hs_edge_q.size() > 0) begin
      check("latency", obs_edge_q[0] - hs_edge_q[0], 2);
      check("single_throughput", obs_edge_q[1] - obs_edge_q[0], 1);
    end

    // All requesters busy: strict rotation, one result per cycle.
    do_reset();
    obs_q.delete();
    obs_edge_q.delete();
    load_all(5);
    drain(200);
    check_rr_ids("rr", 20);
    for (int j = 1; j < obs_edge_q.size(); j++)
      check("rr_throughput", obs_edge_q[j] - obs_edge_q[j-1], 1);

    // Output stall for five cycles in the middle of a stream.
    do_reset();
    obs_q.delete();
    load_all(6);
    repeat (4) @(posedge iClk);
    #2 out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge iClk);
      #2;
      if (c == 2 || c == 5) begin
        check("stall_req_ready", req_ready, 0);
        check("stall_busy", busy, 1);
        check("stall_out_valid", out_valid, 1);
      end
    end
    out_ready = 1'b1;
    drain(200);
    check_rr_ids("stall", 24);

    // Asynchronous reset between edges in the middle of a stream.
    do_reset();
    load_all(6);
    repeat (3) @(posedge iClk);
    #2 iRst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_req_ready", req_ready, 0);
    obs_q.delete();
    @(negedge iClk);
    @(posedge iClk);
    #1 iRst = 1'b0;
    #1;
    check("post_reset_grant", req_ready, 4'b0001);
    drain(200);
    total++;
    if (obs_q.size() == 0) begin
      bad++;
      $display("FAIL post_reset_results: got 0 results, expected at least 1");
    end else begin
      check("post_reset_first_id", obs_q[0][11:10], 0);
    end

    repeat (2) @(posedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
